// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, fetches 16-bit words over a req/ack handshake and
// feeds decode from a 2-entry {pc, word} queue; supports redirect flush and HALT stop.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              halted
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [1:0]          cnt_q, cnt_d, wr_idx;
    logic [ADDR_W+15:0]  q0_q, q0_d, q1_q, q1_d, ent;
    logic                req_q, req_d, halted_q, halted_d;
    logic                xfer, pop;

    assign xfer   = req_q && imem_ack;
    assign pop    = (cnt_q != 2'd0) && instr_ready;
    assign ent    = {pc_q, imem_rdata};
    assign wr_idx = cnt_q - {1'b0, pop};

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        q0_d    = q0_q;
        q1_d    = q1_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            cnt_d   = 2'd0;
            state_d = IDLE;
        end else begin
            if (pop) q0_d = q1_q;
            if (xfer) begin
                pc_d = pc_q + 1'b1;
                if (wr_idx == 2'd0) q0_d = ent;
                else q1_d = ent;
            end
            cnt_d   = cnt_q + {1'b0, xfer} - {1'b0, pop};
            state_d = (state_q == IDLE) ? RUN :
                      (state_q == RUN && xfer && imem_rdata[15:12] == HALT_OP) ? HALTED : state_q;
        end
        // request drops in the same cycle the queue fills
        req_d    = (state_d == RUN) && (cnt_d != 2'd2);
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            cnt_q    <= 2'd0;
            q0_q     <= '0;
            q1_q     <= '0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            q0_q     <= q0_d;
            q1_q     <= q1_d;
            req_q    <= req_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = (cnt_q != 2'd0);
    assign instr       = q0_q[15:0];
    assign instr_pc    = q0_q[ADDR_W+15:16];
    assign halted      = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of streaming, back-pressure, redirect, HALT, wrap with slow memory and async reset.
module tb_fetch_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        imem_req, imem_ack, instr_valid, halted;
    logic        redirect_valid = 1'b0, instr_ready = 1'b1;
    logic [7:0]  imem_addr, instr_pc, redirect_pc = 8'h00;
    logic [15:0] imem_rdata, instr;
    logic        slow = 1'b0, halt_en = 1'b0;
    logic [7:0]  halt_addr = 8'h00;
    int          wcnt = 0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_OP(4'hF)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .halted(halted)
    );

    // memory: word = 16'h1000 | addr, optional HALT word, ack immediate or 3 cycles after request
    assign imem_rdata = (halt_en && imem_addr == halt_addr) ? 16'hF000 : {8'h10, imem_addr};
    assign imem_ack   = slow ? (wcnt == 3) : 1'b1;
    always @(posedge clk) wcnt <= (!imem_req || imem_ack || redirect_valid) ? 0 : wcnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_head(input logic [7:0] p);
        logic seen = 1'b0;
        for (int n = 0; n < 25 && !seen; n++) begin
            @(negedge clk);
            if (instr_valid) begin
                seen = 1'b1;
                chk("wrap_pc", instr_pc, p);
                chk("wrap_instr", instr, {8'h10, p});
            end else if (imem_req && !imem_ack) begin
                chk("addr_hold", imem_addr, p);
            end
        end
        if (!seen) chk("head_timeout", seen, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("first_req", imem_req, 1);
        chk("first_valid", instr_valid, 0);
        chk("first_addr", imem_addr, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("str_valid", instr_valid, 1);
            chk("str_pc", instr_pc, i);
            chk("str_instr", instr, 32'h1000 + i);
        end
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req", imem_req, 0);
            chk("bp_valid", instr_valid, 1);
            chk("bp_pc", instr_pc, 3);
            chk("bp_instr", instr, 32'h1003);
        end
        instr_ready = 1'b1;
        for (int i = 4; i < 7; i++) begin
            @(negedge clk);
            chk("bp_order_pc", instr_pc, i);
            chk("bp_order_instr", instr, 32'h1000 + i);
            if (i == 4) chk("bp_resume_req", imem_req, 1);
        end
        chk("rd_ack_same_cycle", imem_ack && imem_req, 1);
        redirect_pc = 8'h40;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rd_valid", instr_valid, 0);
        chk("rd_req", imem_req, 0);
        chk("rd_addr", imem_addr, 8'h40);
        @(negedge clk);
        chk("rd_req2", imem_req, 1);
        chk("rd_addr2", imem_addr, 8'h40);
        @(negedge clk);
        chk("rd_head_valid", instr_valid, 1);
        chk("rd_head_pc", instr_pc, 8'h40);
        chk("rd_head_instr", instr, 32'h1040);
        halt_en = 1'b1;
        halt_addr = 8'h03;
        redirect_pc = 8'h00;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_pc", instr_pc, i);
            chk("halt_instr", instr, (i == 3) ? 32'hF000 : 32'h1000 + i);
        end
        chk("halt_flag", halted, 1);
        chk("halt_req", imem_req, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_drained", instr_valid, 0);
            chk("halt_stay", halted, 1);
            chk("halt_noreq", imem_req, 0);
        end
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("restart_halted", halted, 0);
        chk("restart_req0", imem_req, 0);
        @(negedge clk);
        chk("restart_req", imem_req, 1);
        chk("restart_addr", imem_addr, 0);
        @(negedge clk);
        chk("restart_pc", instr_pc, 0);
        chk("restart_valid", instr_valid, 1);
        slow = 1'b1;
        redirect_pc = 8'hFE;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("wrap_idle_req", imem_req, 0);
        wait_head(8'hFE);
        wait_head(8'hFF);
        wait_head(8'h00);
        slow = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        chk("ar_full_valid", instr_valid, 1);
        chk("ar_full_req", imem_req, 0);
        chk("ar_full_pc", instr_pc, 0);
        chk("ar_full_addr", imem_addr, 8'h02);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", instr_valid, 0);
        chk("ar_req", imem_req, 0);
        chk("ar_addr", imem_addr, 0);
        chk("ar_halted", halted, 0);
        instr_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ar_restart_req", imem_req, 1);
        chk("ar_restart_addr", imem_addr, 0);
        @(negedge clk);
        chk("ar_restart_valid", instr_valid, 1);
        chk("ar_restart_pc", instr_pc, 0);
        chk("ar_restart_instr", instr, 32'h1000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
